timer_ctrl_master: RTL and testbench
====================================

TIMER_CTRL_MASTER -- requirements
Module: timer_ctrl_master

Interface
REQ-001 SHALL have parameter TICK_W, default 16, width of the tick_count output.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to program and start the timer; honoured only in IDLE.
REQ-005 SHALL have port period, input, 32, timer period loaded on start.
REQ-006 SHALL have port continuous, input, 1, continuous mode flag loaded on start.
REQ-007 SHALL have port stop, input, 1, one-cycle stop request; honoured only in RUN.
REQ-008 SHALL have port snap_req, input, 1, one-cycle snapshot request; honoured only in RUN.
REQ-009 SHALL have ports busy (out,1, high when state is not IDLE or RUN), tick (out,1, one-cycle pulse per serviced timeout), tick_count (out,TICK_W, wrapping timeout count), snap_value (out,32), snap_valid (out,1, one-cycle pulse).
REQ-010 SHALL have Avalon-MM master ports av_address (out,3), av_chipselect (out,1), av_write_n (out,1), av_writedata (out,16), av_readdata (in,16), av_irq (in,1, timer interrupt).

Function
REQ-011 SHALL use the timer register map: 0 status (write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
REQ-012 SHALL drive every access as a single cycle with av_chipselect=1; writes have av_write_n=0; reads have av_write_n=1; idle cycles have av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
REQ-013 SHALL sample av_readdata one cycle after the read address is presented (read latency 1).
REQ-014 SHALL implement states IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, SNAP_WR, RD_L, RD_L_WAIT, RD_H, RD_H_WAIT.
REQ-015 On start in IDLE, SHALL latch period/continuous, then issue in consecutive cycles: write 2 = period[15:0], write 3 = period[31:16], write 1 = {0,1,continuous,1} (0x7 or 0x5), then enter RUN.
REQ-016 In RUN, priority SHALL be av_irq > stop > snap_req; unserviced lower-priority requests are dropped.
REQ-017 On av_irq in RUN, SHALL write 0 to address 0 (CLR_ST), pulse tick and increment tick_count in that same cycle, then return to RUN unless continuous=0, in which case go to IDLE.
REQ-018 On stop in RUN, SHALL write 0x8 to address 1 (WR_STOP), then go to IDLE.
REQ-019 On snap_req in RUN, SHALL write 0 to address 4, read address 4, wait, read address 5, wait; then present snap_value={high,low} with snap_valid pulsed one cycle, and return to RUN.
REQ-020 tick_count SHALL wrap from all-ones to 0 and SHALL clear to 0 on every accepted start.
REQ-021 av_irq asserted outside RUN SHALL be ignored until RUN is re-entered (still asserted then = serviced).
REQ-022 start/stop/snap_req in states where not honoured SHALL be ignored, with no outputs affected.

Reset
REQ-023 On reset_n low, SHALL go to IDLE immediately; busy, tick, snap_valid, tick_count, snap_value=0; Avalon outputs at idle values; any in-flight sequence is abandoned without completion.

Structure
REQ-024 Register addresses, control bit positions, and state encoding SHALL live in a shared timer package used by this block and its bench.
REQ-025 SHALL be a single module; no sub-modules.

Verification
REQ-026 Reset then start, period=0x0001_86A0, continuous=1 -> writes (2,0x86A0),(3,0x0001),(1,0x0007) in 3 consecutive cycles; busy=0 in RUN.
REQ-027 In RUN assert av_irq -> next cycle write (0,0x0000), tick pulse, tick_count 0->1; repeat 3 irqs -> tick_count=4.
REQ-028 continuous=0, one irq -> status clear, then IDLE; later irq -> no access, no tick.
REQ-029 snap_req, model returns 0x1234 at addr4 and 0x0005 at addr5 -> snap_value=0x0005_1234, snap_valid for 1 cycle.
REQ-030 av_irq and stop in same RUN cycle -> status clear first; stop dropped; state RUN.
REQ-031 reset_n low during WR_PH -> all outputs at reset values same cycle; after release no further writes occur.

Source files
------------

// File: rtl/timer_ctrl_master_pkg.sv
// Shared definitions for the timer control master: Avalon register map,
// control bit positions, FSM state encoding and a control-word helper.
package timer_ctrl_master_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    CLR_ST,
    WR_STOP,
    SNAP_WR,
    RD_L,
    RD_L_WAIT,
    RD_H,
    RD_H_WAIT
  } state_e;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic strt, input logic stp);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = strt;
    w[CTRL_STOP]  = stp;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM bundle between the timer control master and the timer slave.
// Every access is one cycle wide: chipselect=1 marks it, write_n=0 selects a
// write; read data is valid on the cycle after the read address (latency 1).
interface timer_ctrl_master_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_irq;

  modport master (
    output av_address, av_chipselect, av_write_n, av_writedata,
    input  av_readdata, av_irq
  );

  modport slave (
    input  av_address, av_chipselect, av_write_n, av_writedata,
    output av_readdata, av_irq
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// Programs an Avalon-MM interval timer, services its timeout interrupt,
// handles stop requests and reads back 32-bit snapshots of the counter.
module timer_ctrl_master
  import timer_ctrl_master_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       period,
  input  logic              continuous,
  input  logic              stop,
  input  logic              snap_req,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              av_irq,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [31:0]       period_q, period_d;
  logic              cont_q, cont_d;
  logic [TICK_W-1:0] tick_count_q, tick_count_d;
  logic [15:0]       snap_lo_q, snap_lo_d;
  logic [31:0]       snap_value_q, snap_value_d;
  logic              snap_valid_q, snap_valid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      tick_count_q <= tick_count_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  // Bus outputs are decoded from the current state only, so an async reset
  // returns them to idle values in the same cycle.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    cont_d        = cont_q;
    tick_count_d  = tick_count_q;
    snap_lo_d     = snap_lo_q;
    snap_value_d  = snap_value_q;
    snap_valid_d  = 1'b0;
    tick          = 1'b0;
    av_address    = 3'd0;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_writedata  = 16'h0000;

    case (state_q)
      IDLE: begin
        if (start) begin
          period_d     = period;
          cont_d       = continuous;
          tick_count_d = '0;
          state_d      = WR_PL;
        end
      end
      WR_PL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = ADDR_PERIOD_L;
        av_writedata  = period_q[15:0];
        state_d       = WR_PH;
      end
      WR_PH: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = ADDR_PERIOD_H;
        av_writedata  = period_q[31:16];
        state_d       = WR_CTRL;
      end
      WR_CTRL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = ADDR_CONTROL;
        av_writedata  = ctrl_word(1'b1, cont_q, 1'b1, 1'b0);
        state_d       = RUN;
      end
      RUN: begin
        // Timeout beats stop beats snapshot; losers are simply dropped.
        if (av_irq) begin
          tick_count_d = tick_count_q + TICK_W'(1);
          state_d      = CLR_ST;
        end else if (stop) begin
          state_d = WR_STOP;
        end else if (snap_req) begin
          state_d = SNAP_WR;
        end
      end
      CLR_ST: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = ADDR_STATUS;
        tick          = 1'b1;
        state_d       = cont_q ? RUN : IDLE;
      end
      WR_STOP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = ADDR_CONTROL;
        av_writedata  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        state_d       = IDLE;
      end
      SNAP_WR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = ADDR_SNAP_L;
        state_d       = RD_L;
      end
      RD_L: begin
        av_chipselect = 1'b1;
        av_address    = ADDR_SNAP_L;
        state_d       = RD_L_WAIT;
      end
      RD_L_WAIT: begin
        snap_lo_d = av_readdata;
        state_d   = RD_H;
      end
      RD_H: begin
        av_chipselect = 1'b1;
        av_address    = ADDR_SNAP_H;
        state_d       = RD_H_WAIT;
      end
      RD_H_WAIT: begin
        snap_value_d = {av_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE) && (state_q != RUN);
  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master: directed scenarios plus randomized requests
// checked against a transaction-level model of expected bus accesses.
module tb_timer_ctrl_master;
  import timer_ctrl_master_pkg::*;

  localparam int TW = 4;
  localparam int W  = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   period = '0;
  logic          continuous = 1'b0;
  logic          stop = 1'b0;
  logic          snap_req = 1'b0;
  logic          busy, tick, snap_valid;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value;
  state_e        dbg_state;

  timer_ctrl_master_if av_bus();

  timer_ctrl_master #(.TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .period(period),
    .continuous(continuous), .stop(stop), .snap_req(snap_req),
    .busy(busy), .tick(tick), .tick_count(tick_count),
    .snap_value(snap_value), .snap_valid(snap_valid),
    .av_address(av_bus.av_address), .av_chipselect(av_bus.av_chipselect),
    .av_write_n(av_bus.av_write_n), .av_writedata(av_bus.av_writedata),
    .av_readdata(av_bus.av_readdata), .av_irq(av_bus.av_irq),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- slave memory model (read latency 1) ----------------
  logic [15:0] mem4 = 16'h0, mem5 = 16'h0;

  initial av_bus.av_irq = 1'b0;

  always @(posedge clk) begin
    if (av_bus.av_chipselect && av_bus.av_write_n)
      av_bus.av_readdata <= (av_bus.av_address == ADDR_SNAP_L) ? mem4 :
                            (av_bus.av_address == ADDR_SNAP_H) ? mem5 : 16'h0;
    else
      av_bus.av_readdata <= 16'h0;
  end

  // ---------------- monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           tick_seen = 0;
  int           snap_seen = 0;
  logic [31:0]  snap_last = '0;

  always @(negedge clk) begin
    if (av_bus.av_chipselect === 1'b1) begin
      if (av_bus.av_write_n === 1'b0)
        obs_q.push_back({1'b1, av_bus.av_address, av_bus.av_writedata});
      else
        obs_q.push_back({1'b0, av_bus.av_address, 16'h0000});
    end
    if (tick === 1'b1) tick_seen++;
    if (snap_valid === 1'b1) begin
      snap_seen++;
      snap_last = snap_value;
    end
  end

  // ---------------- reference model ----------------
  bit            m_run = 0;
  bit            m_cont = 0;
  int            m_ticks = 0;
  int            m_snaps = 0;
  logic [TW-1:0] m_tcount = '0;
  logic [31:0]   m_snap_val = '0;

  task automatic m_cycle(input logic s, input logic [31:0] p, input logic c,
                         input logic sp, input logic irq, input logic sn);
    if (!m_run) begin
      if (s) begin
        exp_q.push_back({1'b1, ADDR_PERIOD_L, p[15:0]});
        exp_q.push_back({1'b1, ADDR_PERIOD_H, p[31:16]});
        exp_q.push_back({1'b1, ADDR_CONTROL, (c ? 16'h0007 : 16'h0005)});
        m_run    = 1;
        m_cont   = c;
        m_tcount = '0;
      end
    end else if (irq) begin
      exp_q.push_back({1'b1, ADDR_STATUS, 16'h0000});
      m_ticks++;
      m_tcount = m_tcount + 1'b1;
      if (!m_cont) m_run = 0;
    end else if (sp) begin
      exp_q.push_back({1'b1, ADDR_CONTROL, 16'h0008});
      m_run = 0;
    end else if (sn) begin
      exp_q.push_back({1'b1, ADDR_SNAP_L, 16'h0000});
      exp_q.push_back({1'b0, ADDR_SNAP_L, 16'h0000});
      exp_q.push_back({1'b0, ADDR_SNAP_H, 16'h0000});
      m_snaps++;
      m_snap_val = {mem5, mem4};
    end
  endtask

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_bus(input string tag);
    chk({tag, "_nacc"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_acc"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_all(input string tag);
    compare_bus(tag);
    chk({tag, "_tick_count"}, tick_count, m_tcount);
    chk({tag, "_ticks"}, tick_seen, m_ticks);
    chk({tag, "_snaps"}, snap_seen, m_snaps);
    chk({tag, "_snap_val"}, snap_last, m_snap_val);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_state"}, dbg_state, (m_run ? RUN : IDLE));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_tick"}, tick, 1'b0);
    chk({tag, "_snap_valid"}, snap_valid, 1'b0);
    chk({tag, "_tick_count"}, tick_count, '0);
    chk({tag, "_snap_value"}, snap_value, 32'h0);
    chk({tag, "_cs"}, av_bus.av_chipselect, 1'b0);
    chk({tag, "_write_n"}, av_bus.av_write_n, 1'b1);
    chk({tag, "_addr"}, av_bus.av_address, 3'd0);
    chk({tag, "_wdata"}, av_bus.av_writedata, 16'h0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  task automatic chk_write(input string tag, input logic [2:0] a, input logic [15:0] d);
    chk({tag, "_cs"}, av_bus.av_chipselect, 1'b1);
    chk({tag, "_write_n"}, av_bus.av_write_n, 1'b0);
    chk({tag, "_addr"}, av_bus.av_address, a);
    chk({tag, "_wdata"}, av_bus.av_writedata, d);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic s, input logic [31:0] p, input logic c,
                       input logic sp, input logic irq, input logic sn);
    @(negedge clk);
    start = s; period = p; continuous = c; stop = sp;
    av_bus.av_irq = irq; snap_req = sn;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; av_bus.av_irq = 1'b0; snap_req = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic op(input logic s, input logic [31:0] p, input logic c,
                    input logic sp, input logic irq, input logic sn);
    m_cycle(s, p, c, sp, irq, sn);
    drive(s, p, c, sp, irq, sn);
    settle(8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    settle(2);

    // programming sequence with continuous=1
    m_cycle(1'b1, 32'h0001_86A0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0001_86A0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_write("prog_pl", ADDR_PERIOD_L, 16'h86A0);
    chk("prog_busy", busy, 1'b1);
    @(negedge clk);
    chk_write("prog_ph", ADDR_PERIOD_H, 16'h0001);
    @(negedge clk);
    chk_write("prog_ctrl", ADDR_CONTROL, 16'h0007);
    @(negedge clk);
    chk("run_busy", busy, 1'b0);
    chk("run_state", dbg_state, RUN);
    settle(2);
    check_all("start");

    // first timeout: status clear, tick and count in the same cycle
    m_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_write("clr", ADDR_STATUS, 16'h0000);
    chk("clr_tick", tick, 1'b1);
    chk("clr_count", tick_count, 1);
    settle(4);
    check_all("irq1");
    for (int i = 0; i < 3; i++) op(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("irq4_count", tick_count, 4);
    check_all("irq4");

    // irq and stop together: irq wins, stop dropped
    op(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("irq_stop");

    // snapshot
    mem4 = 16'h1234;
    mem5 = 16'h0005;
    op(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("snap_value", snap_last, 32'h0005_1234);
    check_all("snap");

    op(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all("stop");

    // one-shot: single irq then idle, later irq ignored
    op(1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("oneshot");
    op(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("idle_irq");
    op(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_all("idle_stop_snap");

    // irq held through IDLE is serviced once RUN is reached
    @(negedge clk);
    av_bus.av_irq = 1'b1;
    settle(4);
    check_all("held_irq_idle");
    m_cycle(1'b1, 32'hCAFE_0123, 1'b1, 1'b0, 1'b0, 1'b0);
    m_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; period = 32'hCAFE_0123; continuous = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    av_bus.av_irq = 1'b0;
    settle(6);
    check_all("held_irq_run");

    // tick_count wrap
    for (int i = 0; i < 16; i++) op(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap_count", tick_count, 1);
    check_all("wrap");

    // randomized requests
    for (int i = 0; i < 40; i++) begin
      logic        s, c, sp, irq, sn;
      logic [31:0] p;
      s    = ($urandom_range(0, 2) == 0);
      c    = 1'($urandom_range(0, 1));
      sp   = ($urandom_range(0, 5) == 0);
      irq  = ($urandom_range(0, 3) == 0);
      sn   = ($urandom_range(0, 2) == 0);
      p    = $urandom();
      mem4 = 16'($urandom_range(0, 65535));
      mem5 = 16'($urandom_range(0, 65535));
      op(s, p, c, sp, irq, sn);
      check_all("rnd");
    end
    op(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all("rnd_stop");

    // reset in the middle of programming
    exp_q.push_back({1'b1, ADDR_PERIOD_L, 16'h5678});
    exp_q.push_back({1'b1, ADDR_PERIOD_H, 16'h1234});
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_write("mid_ph", ADDR_PERIOD_H, 16'h1234);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_run    = 0;
    m_tcount = '0;
    @(negedge clk);
    reset_n = 1'b1;
    settle(6);
    check_all("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
